branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Consumes the eq/ltu/lt flags from the branch condition generator in the OTTER execute stage. Decodes the RISC-V branch func3 into a taken/not-taken decision and drives a registered PC redirect to fetch over a valid/ready handshake. Stalls execute while a redirect is pending, then issues a one-cycle flush to squash the wrong-path IF/ID instructions. Optional performance counters track resolved and taken branches.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (saturating)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents a control-transfer instruction
- ex_ready  out  1  unit accepts the instruction this cycle
- ex_jump  in  1  JAL/JALR: taken unconditionally, func3 ignored
- func3  in  3  branch func3 field
- eq, ltu, lt  in  1 each  flags from the branch condition generator
- target  in  32  computed branch/jump target
- stall_ex  out  1  hold execute stage
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  32  redirect address
- flush  out  1  squash IF/ID, one-cycle pulse
- illegal  out  1  one-cycle pulse: func3 = 010 or 011 on a branch
- misalign  out  1  one-cycle pulse: taken target with target[1:0] != 0
- branch_cnt  out  CNT_W  resolved branches (only with BRU_PERF_CNT_EN)
- taken_cnt  out  CNT_W  taken transfers (only with BRU_PERF_CNT_EN)

## Operation
- Decision: 000 eq; 001 ~eq; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu; 010/011 not taken + illegal. ex_jump=1 forces taken, never illegal.
- States: IDLE, REDIR, FLUSH.
- IDLE: ex_ready=1. On ex_valid:
  - taken, target[1:0]==0: latch target into redir_pc, go REDIR.
  - taken, misaligned: pulse misalign next cycle, no redirect, stay IDLE.
  - not taken / illegal: stay IDLE, no redirect.
- REDIR: redir_valid=1, stall_ex=1, ex_ready=0, redir_pc held stable. On redir_ready go FLUSH; otherwise hold indefinitely.
- FLUSH: flush=1, stall_ex=0, ex_ready=0, redir_valid=0; go IDLE next cycle.
- ex_valid in REDIR/FLUSH is ignored (not accepted).
- Counters: branch_cnt increments on every accepted ex_valid (including illegal, misaligned, jumps); taken_cnt on every accepted taken decision (including misaligned). Both saturate at all-ones.

## Timing
- Reset (async assert, sync-to-clk release): state IDLE; redir_valid, stall_ex, flush, illegal, misalign = 0; redir_pc = 0; counters = 0; ex_ready = 1.
- Accept at edge N (taken) -> redir_valid and stall_ex high from cycle N+1.
- redir_ready sampled same cycle as redir_valid; accept at edge M -> flush high in cycle M+1 only, ex_ready high again in cycle M+2.
- Minimum taken-branch turnaround: 3 cycles (IDLE->REDIR->FLUSH->IDLE); not-taken: back-to-back every cycle.
- illegal/misalign asserted exactly in cycle N+1, one cycle wide.
- All outputs registered except ex_ready and stall_ex (decoded from state).
- rst_n asserted mid-REDIR: redirect dropped immediately, no flush issued.

## Configuration
- BRU_PERF_CNT_EN defined: branch_cnt/taken_cnt registers implemented as above.
- Undefined: counter registers omitted; branch_cnt and taken_cnt tied to 0; no other behaviour changes.

## Test plan
- Reset: rst_n=0 mid-REDIR with redir_pc=0x100 -> all outputs 0 immediately, ex_ready=1, no flush after release.
- BEQ eq=1, target=0x0000_0040, redir_ready=1 -> redir_valid at N+1 with redir_pc=0x40, flush at N+2, ex_ready at N+3.
- BLTU ltu=0 then BGE lt=0 on consecutive cycles, target=0x80 -> first not taken, second redirect to 0x80; branch_cnt=2, taken_cnt=1.
- Backpressure: BNE eq=0, redir_ready=0 for 5 cycles -> redir_valid, stall_ex, redir_pc=target held 5 cycles; ex_valid ignored; flush only after redir_ready.
- func3=010 with ex_jump=0 -> illegal pulse at N+1, no redirect; ex_jump=1, target=0x102 -> misalign pulse, no redirect, taken_cnt incremented.
- Counter saturation (CNT_W=4, BRU_PERF_CNT_EN defined): 20 taken jumps -> branch_cnt and taken_cnt stay 0xF.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Branch resolution for the OTTER execute stage: func3 decode, registered PC redirect
// handshake, execute stall and one-cycle IF/ID flush. Optional counters: BRU_PERF_CNT_EN.
module branch_resolution_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic             ex_jump,
   input  logic [2:0]       func3,
   input  logic             eq,
   input  logic             ltu,
   input  logic             lt,
   input  logic [31:0]      target,
   output logic             stall_ex,
   output logic             redir_valid,
   input  logic             redir_ready,
   output logic [31:0]      redir_pc,
   output logic             flush,
   output logic             illegal,
   output logic             misalign,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_t;

   state_t      state_reg, state_next;
   logic        taken, bad_func3, accept, aligned;
   logic        redir_valid_reg, flush_reg, illegal_reg, misalign_reg;
   logic [31:0] redir_pc_reg;

   always_comb begin
      taken     = 1'b0;
      bad_func3 = 1'b0;
      if (ex_jump) begin
         taken = 1'b1;
      end else begin
         case (func3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: bad_func3 = 1'b1;
         endcase
      end
   end

   assign accept  = ex_valid && (state_reg == IDLE);
   assign aligned = (target[1:0] == 2'b00);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept && taken && aligned) state_next = REDIR;
         REDIR:   if (redir_ready) state_next = FLUSH;
         FLUSH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake/flush outputs are registered copies of the next state so they
   // line up exactly with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         redir_valid_reg <= 1'b0;
         flush_reg       <= 1'b0;
         illegal_reg     <= 1'b0;
         misalign_reg    <= 1'b0;
         redir_pc_reg    <= 32'h0;
      end else begin
         state_reg       <= state_next;
         redir_valid_reg <= (state_next == REDIR);
         flush_reg       <= (state_next == FLUSH);
         illegal_reg     <= accept && bad_func3;
         misalign_reg    <= accept && taken && !aligned;
         if (accept && taken && aligned)
            redir_pc_reg <= target;
      end
   end

   assign ex_ready    = (state_reg == IDLE);
   assign stall_ex    = (state_reg == REDIR);
   assign redir_valid = redir_valid_reg;
   assign flush       = flush_reg;
   assign illegal     = illegal_reg;
   assign misalign    = misalign_reg;
   assign redir_pc    = redir_pc_reg;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] branch_cnt_reg, taken_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_reg <= '0;
         taken_cnt_reg  <= '0;
      end else if (accept) begin
         if (branch_cnt_reg != {CNT_W{1'b1}})
            branch_cnt_reg <= branch_cnt_reg + 1'b1;
         if (taken && (taken_cnt_reg != {CNT_W{1'b1}}))
            taken_cnt_reg <= taken_cnt_reg + 1'b1;
      end
   end

   assign branch_cnt = branch_cnt_reg;
   assign taken_cnt  = taken_cnt_reg;
`else
   assign branch_cnt = '0;
   assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: behavioural model with per-cycle
// compare, directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolution_unit;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef BRU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic ex_valid = 1'b0, ex_jump = 1'b0, eq = 1'b0, ltu = 1'b0, lt = 1'b0, redir_ready = 1'b0;
   logic [2:0]  func3 = 3'b0;
   logic [31:0] target = 32'h0;
   logic        ex_ready, stall_ex, redir_valid, flush, illegal, misalign;
   logic [31:0] redir_pc;
   logic [CNT_W-1:0] branch_cnt, taken_cnt;

   int n_chk = 0, n_fail = 0;

   branch_resolution_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_jump(ex_jump), .func3(func3), .eq(eq), .ltu(ltu), .lt(lt),
      .target(target), .stall_ex(stall_ex), .redir_valid(redir_valid),
      .redir_ready(redir_ready), .redir_pc(redir_pc), .flush(flush),
      .illegal(illegal), .misalign(misalign), .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V branch semantics straight from the func3 table
   function automatic bit decide(bit j, logic [2:0] f, bit e, bit u, bit s);
      if (j) return 1'b1;
      case (f)
         3'b000:  return e;
         3'b001:  return !e;
         3'b100:  return s;
         3'b101:  return !s;
         3'b110:  return u;
         3'b111:  return !u;
         default: return 1'b0;
      endcase
   endfunction

   // Model: a pending redirect waits for fetch, then one flush cycle, then idle.
   bit          m_pending, m_flush, m_ill, m_mis;
   logic [31:0] m_pc;
   int          m_bc, m_tc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending <= 1'b0; m_flush <= 1'b0; m_ill <= 1'b0; m_mis <= 1'b0;
         m_pc <= 32'h0; m_bc <= 0; m_tc <= 0;
      end else begin
         m_ill <= 1'b0;
         m_mis <= 1'b0;
         if (m_pending) begin
            if (redir_ready) begin
               m_pending <= 1'b0;
               m_flush   <= 1'b1;
            end
         end else if (m_flush) begin
            m_flush <= 1'b0;
         end else if (ex_valid) begin
            m_bc <= m_bc + 1;
            if (!ex_jump && (func3 == 3'd2 || func3 == 3'd3)) m_ill <= 1'b1;
            if (decide(ex_jump, func3, eq, ltu, lt)) begin
               m_tc <= m_tc + 1;
               if (target[1:0] != 2'b00) m_mis <= 1'b1;
               else begin
                  m_pending <= 1'b1;
                  m_pc      <= target;
               end
            end
         end
      end
   end

   function automatic int cnt_exp(int v);
      if (!PERF) return 0;
      return (v > CMAX) ? CMAX : v;
   endfunction

   always @(negedge clk) begin
      chk("cmp_ex_ready",    ex_ready,    !m_pending && !m_flush);
      chk("cmp_stall_ex",    stall_ex,    m_pending);
      chk("cmp_redir_valid", redir_valid, m_pending);
      chk("cmp_redir_pc",    redir_pc,    m_pc);
      chk("cmp_flush",       flush,       m_flush);
      chk("cmp_illegal",     illegal,     m_ill);
      chk("cmp_misalign",    misalign,    m_mis);
      chk("cmp_branch_cnt",  branch_cnt,  cnt_exp(m_bc));
      chk("cmp_taken_cnt",   taken_cnt,   cnt_exp(m_tc));
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit j, input logic [2:0] f, input bit e, input bit u,
                        input bit s, input logic [31:0] t);
      ex_valid = 1'b1; ex_jump = j; func3 = f; eq = e; ltu = u; lt = s; target = t;
      cycle();
      ex_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      repeat (2) cycle();
      chk("reset_ex_ready", ex_ready, 1'b1);
      chk("reset_redir_pc", redir_pc, 32'h0);
      rst_n = 1'b1;
      cycle();

      // BEQ taken to 0x40, fetch ready at once
      redir_ready = 1'b1;
      issue(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40);
      @(negedge clk);
      chk("beq_redir_valid", redir_valid, 1'b1);
      chk("beq_redir_pc", redir_pc, 32'h40);
      chk("beq_ex_ready_low", ex_ready, 1'b0);
      cycle();
      @(negedge clk);
      chk("beq_flush", flush, 1'b1);
      chk("beq_redir_dropped", redir_valid, 1'b0);
      cycle();
      @(negedge clk);
      chk("beq_ex_ready_back", ex_ready, 1'b1);
      chk("beq_flush_done", flush, 1'b0);

      // BLTU not taken then BGE taken on consecutive cycles
      do_reset();
      ex_valid = 1'b1; ex_jump = 1'b0; func3 = 3'b110; ltu = 1'b0; lt = 1'b0; target = 32'h80;
      cycle();
      func3 = 3'b101;
      cycle();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("bge_redir_pc", redir_pc, 32'h80);
      chk("bge_branch_cnt", branch_cnt, PERF ? 32'd2 : 32'd0);
      chk("bge_taken_cnt", taken_cnt, PERF ? 32'd1 : 32'd0);
      repeat (2) cycle();

      // BNE under 5 cycles of fetch backpressure, with ignored ex_valid traffic
      redir_ready = 1'b0;
      issue(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h200);
      ex_valid = 1'b1; ex_jump = 1'b1; target = 32'h300;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_redir_valid", redir_valid, 1'b1);
         chk("bp_stall_ex", stall_ex, 1'b1);
         chk("bp_redir_pc", redir_pc, 32'h200);
         chk("bp_no_flush", flush, 1'b0);
         cycle();
      end
      ex_valid = 1'b0; redir_ready = 1'b1;
      cycle();
      @(negedge clk);
      chk("bp_flush", flush, 1'b1);
      cycle();

      // Illegal func3, then misaligned jump
      issue(1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h40);
      @(negedge clk);
      chk("ill_pulse", illegal, 1'b1);
      chk("ill_no_redir", redir_valid, 1'b0);
      cycle();
      @(negedge clk);
      chk("ill_one_cycle", illegal, 1'b0);
      issue(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'h102);
      @(negedge clk);
      chk("mis_pulse", misalign, 1'b1);
      chk("mis_no_illegal", illegal, 1'b0);
      chk("mis_no_redir", redir_valid, 1'b0);
      cycle();

      // Reset asserted while a redirect to 0x100 is pending
      redir_ready = 1'b0;
      issue(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_redir_valid", redir_valid, 1'b0);
      chk("rst_stall_ex", stall_ex, 1'b0);
      chk("rst_redir_pc", redir_pc, 32'h0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      redir_ready = 1'b1;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_flush", flush, 1'b0);
         cycle();
      end

      // Counter saturation: 20 taken jumps
      do_reset();
      for (int i = 0; i < 20; i++) begin
         issue(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i * 4));
         repeat (2) cycle();
      end
      @(negedge clk);
      chk("sat_branch_cnt", branch_cnt, PERF ? 32'hF : 32'h0);
      chk("sat_taken_cnt", taken_cnt, PERF ? 32'hF : 32'h0);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ex_valid    = ($urandom_range(9) < 7);
         ex_jump     = ($urandom_range(4) == 0);
         func3       = 3'($urandom_range(7));
         eq          = 1'($urandom);
         ltu         = 1'($urandom);
         lt          = 1'($urandom);
         target      = $urandom();
         if ($urandom_range(3) != 0) target[1:0] = 2'b00;
         redir_ready = ($urandom_range(9) < 6);
         cycle();
      end
      ex_valid = 1'b0;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
